// File: rtl/layer_mem_bank.sv
// Multi-bank layer memory with registered read port, per-bank write status and an
// optional out-of-range access flag enabled by the LAYER_MEM_OOB_CHK_EN macro.
module layer_mem_bank #(
    parameter int DW    = 20,
    parameter int AW    = 12,
    parameter int DEPTH = 4096,
    parameter int NBANK = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               csel,
    input  logic                     cwr,
    input  logic [AW-1:0]            caddr_wr,
    input  logic [DW-1:0]            cdata_wr,
    input  logic                     crd,
    input  logic [AW-1:0]            caddr_rd,
    output logic [DW-1:0]            cdata_rd,
    input  logic                     clear,
    output logic [NBANK-1:0]         wr_seen,
    output logic [NBANK*(AW+1)-1:0]  wr_cnt,
    output logic                     err
);

    localparam int          MIW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_MAX = {(AW+1){1'b1}};
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [NBANK-1:0] bank_hit_s;
    logic             any_hit_s;
    logic             wr_in_range_s;
    logic             rd_in_range_s;
    logic             wr_ok_s;
    logic             rd_ok_s;
    logic [MIW-1:0]   wr_idx_s;
    logic [MIW-1:0]   rd_idx_s;
    logic [DW-1:0]    bank_rd_s [NBANK];
    logic [DW-1:0]    rd_mux_s;
    logic [DW-1:0]    cdata_rd_r;

    // Address range checks and strobe qualification; strobes seen under reset are dropped
    always_comb begin
        wr_in_range_s = ({1'b0, caddr_wr} < DEPTH_W);
        rd_in_range_s = ({1'b0, caddr_rd} < DEPTH_W);
        any_hit_s     = |bank_hit_s;
        wr_ok_s       = any_hit_s & cwr & wr_in_range_s & ~reset;
        rd_ok_s       = any_hit_s & crd;
        wr_idx_s      = caddr_wr[MIW-1:0];
        rd_idx_s      = caddr_rd[MIW-1:0];
    end

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        logic [DW-1:0] mem_r [DEPTH];
        logic [AW:0]   cnt_r;
        logic          seen_r;

        // Bank i answers to the odd select code 2*i+1 only
        assign bank_hit_s[g] = (csel == 3'(2*g+1));

        // Write port; contents intentionally survive reset
        always_ff @(posedge clk) begin
            if (wr_ok_s && bank_hit_s[g]) begin
                mem_r[wr_idx_s] <= cdata_wr;
            end
        end

        assign bank_rd_s[g] = mem_r[rd_idx_s];

        // Write status: clear wins over a same-edge write, counter saturates
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_r  <= {(AW+1){1'b0}};
                seen_r <= 1'b0;
            end else if (clear) begin
                cnt_r  <= {(AW+1){1'b0}};
                seen_r <= 1'b0;
            end else if (wr_ok_s && bank_hit_s[g]) begin
                seen_r <= 1'b1;
                if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end
        end

        assign wr_seen[g]                  = seen_r;
        assign wr_cnt[g*(AW+1) +: (AW+1)]  = cnt_r;
    end

    // One-hot read mux across banks
    always_comb begin
        rd_mux_s = {DW{1'b0}};
        for (int i = 0; i < NBANK; i++) begin
            rd_mux_s = rd_mux_s | (bank_rd_s[i] & {DW{bank_hit_s[i]}});
        end
    end

    // Registered read: old data on a same-edge write, zero when out of range, hold otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdata_rd_r <= {DW{1'b0}};
        end else if (rd_ok_s) begin
            cdata_rd_r <= rd_in_range_s ? rd_mux_s : {DW{1'b0}};
        end
    end

    assign cdata_rd = cdata_rd_r;

`ifdef LAYER_MEM_OOB_CHK_EN
    logic oob_s;
    logic err_r;

    // Any selected access beyond DEPTH is an out-of-range event
    always_comb begin
        oob_s = any_hit_s & ((cwr & ~wr_in_range_s) | (crd & ~rd_in_range_s));
    end

    // Sticky error flag, released only by reset or clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (clear) begin
            err_r <= 1'b0;
        end else if (oob_s) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/layer_mem_bank.md
LAYER_MEM_BANK -- requirements
Module: layer_mem_bank

Interface
REQ-001 SHALL have parameter DW, default 20: data width of every memory word.
REQ-002 SHALL have parameter AW, default 12: read and write address width.
REQ-003 SHALL have parameter DEPTH, default 4096: words per bank, 1..2^AW.
REQ-004 SHALL have parameter NBANK, default 2: number of layer banks, 1..4.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port csel, input, 3 bits: bank select; bank i is selected when csel == 2*i+1.
REQ-008 SHALL have port cwr, input, 1 bit: write strobe.
REQ-009 SHALL have port caddr_wr, input, AW bits: write address.
REQ-010 SHALL have port cdata_wr, input, DW bits: write data.
REQ-011 SHALL have port crd, input, 1 bit: read strobe.
REQ-012 SHALL have port caddr_rd, input, AW bits: read address.
REQ-013 SHALL have port cdata_rd, output, DW bits: registered read data.
REQ-014 SHALL have port clear, input, 1 bit: synchronous clear of status state.
REQ-015 SHALL have port wr_seen, output, NBANK bits: sticky flag per bank, set by the first write to that bank.
REQ-016 SHALL have port wr_cnt, output, NBANK*(AW+1) bits: per-bank write counters; bank i occupies bits [i*(AW+1) +: AW+1].
REQ-017 SHALL have port err, output, 1 bit: sticky out-of-range access flag.

Function
REQ-018 SHALL write cdata_wr to the selected bank at caddr_wr on the clock edge where cwr=1 and csel selects a valid bank.
REQ-019 SHALL present on cdata_rd, one cycle after the edge sampling crd=1 with a valid csel, the bank word at caddr_rd (read latency 1).
REQ-020 SHALL hold cdata_rd unchanged in every cycle without a valid read.
REQ-021 SHALL ignore any cwr or crd when csel is even or selects a bank index >= NBANK; no state changes.
REQ-022 SHALL return the pre-write (old) data on a same-cycle read and write to the same bank and address (read-first).
REQ-023 SHALL accept cwr and crd in the same cycle under the single csel; both operations address the selected bank.
REQ-024 SHALL, on each valid in-range write, set wr_seen[i] and increment counter i; the counter saturates at 2^(AW+1)-1 and does not wrap.
REQ-025 SHALL, when clear=1, zero wr_seen, every wr_cnt counter and err on that edge; clear has priority over a simultaneous write's status update, but the memory write still occurs.
REQ-026 SHALL treat an address >= DEPTH as out of range: the write is dropped and the read returns 0 on cdata_rd.
REQ-027 SHALL NOT count out-of-range writes and SHALL NOT set wr_seen for them.

Reset
REQ-028 SHALL, while reset=1, asynchronously force cdata_rd=0, wr_seen=0, all counters=0 and err=0.
REQ-029 SHALL NOT initialise memory contents on reset; contents written before a mid-operation reset are retained.
REQ-030 SHALL resume normal operation on the first rising edge after reset deasserts; strobes sampled while reset=1 are discarded.

Configuration
REQ-031 SHALL, with macro LAYER_MEM_OOB_CHK_EN defined, set err on any valid-csel access (read or write) whose address is >= DEPTH; err stays set until reset or clear.
REQ-032 SHALL, without LAYER_MEM_OOB_CHK_EN, tie err to 0; the REQ-026/REQ-027 drop and zero-return behaviour is unchanged.

Verification
REQ-033 SHALL cover: with csel=001, write 0x12345 to address 5, then read address 5 with csel=001 -> cdata_rd=0x12345 one cycle later; wr_seen=01; bank0 count=1.
REQ-034 SHALL cover: with csel=011, fill bank1 addresses 0..1023, then read them back -> every word matches; bank1 count=1024; bank0 untouched.
REQ-035 SHALL cover: csel=011 with cwr=1 and crd=1 at address 7 (old value 0xAAAAA, new value 0x55555) -> cdata_rd=0xAAAAA; the next read returns 0x55555.
REQ-036 SHALL cover: csel=010 or csel=111 with cwr=1 (NBANK=2) -> memory, counters and wr_seen unchanged.
REQ-037 SHALL cover: DEPTH=1024, AW=12, write to 2000 then read 2000 -> cdata_rd=0; count unchanged; err=1 only with LAYER_MEM_OOB_CHK_EN; clear then returns err to 0.
REQ-038 SHALL cover: reset asserted mid-write burst -> outputs go to 0 immediately; a readback after reset returns the data written before reset.
